// File: rtl/tag_ram_nway_sync.sv
// N-way set-associative tag store: valid bits, synchronous lookup with registered hit/way result.
// Optional TAGRAM_PARITY_EN adds an even-parity bit over {vld, tag} per entry and drives par_err.
module tag_ram_nway_sync #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 14,
  parameter int WAYW   = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  output logic                            init_busy,
  input  logic                            rd_en,
  input  logic [AWIDTH-1:0]               rd_set,
  input  logic [TWIDTH-1:0]               rd_tag,
  input  logic                            wr_en,
  input  logic [AWIDTH-1:0]               wr_set,
  input  logic [WAYW-1:0]                 wr_way,
  input  logic [TWIDTH-1:0]               wr_tag,
  input  logic                            wr_vld,
  output logic                            rsp_vld,
  output logic                            hit,
  output logic [(1<<WAYW)-1:0]            hit_vec,
  output logic [WAYW-1:0]                 hit_idx,
  output logic [(1<<WAYW)*TWIDTH-1:0]     rd_tags,
  output logic [(1<<WAYW)-1:0]            rd_vlds,
  output logic                            par_err
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam int NWAYS = 1 << WAYW;

  typedef enum logic {INIT = 1'b0, IDLE = 1'b1} state_t;

  // Handshake: requests are single-cycle strobes, accepted only when init_busy=0;
  // an accepted rd_en yields exactly one rsp_vld pulse on the following cycle.
  state_t                 state;
  logic [AWIDTH-1:0]      sweep_cnt;
  logic [TWIDTH-1:0]      tag_mem [DEPTH][NWAYS];
  logic [NWAYS-1:0]       vld_mem [DEPTH];
`ifdef TAGRAM_PARITY_EN
  logic                   par_mem [DEPTH][NWAYS];
`endif

  logic                   rd_acc;
  logic                   wr_acc;
  logic [NWAYS-1:0]       bypass;
  logic [NWAYS-1:0]       eff_vld;
  logic [NWAYS*TWIDTH-1:0] eff_tags;
  logic [NWAYS-1:0]       match;
  logic [WAYW-1:0]        match_idx;
  logic                   par_err_d;

  assign init_busy = (state == INIT);
  assign rd_acc    = (state == IDLE) && rd_en;
  assign wr_acc    = (state == IDLE) && wr_en;

  // Write-first view of the looked-up set: a same-cycle fill overrides the stored way.
  always_comb begin
    bypass    = '0;
    eff_vld   = '0;
    eff_tags  = '0;
    match     = '0;
    match_idx = '0;
    par_err_d = 1'b0;
    for (int w = 0; w < NWAYS; w++) begin
      bypass[w] = wr_acc && (wr_set == rd_set) && (wr_way == WAYW'(w));
      eff_tags[w*TWIDTH +: TWIDTH] = bypass[w] ? wr_tag : tag_mem[rd_set][w];
      eff_vld[w] = bypass[w] ? wr_vld : vld_mem[rd_set][w];
      match[w]   = eff_vld[w] && (eff_tags[w*TWIDTH +: TWIDTH] == rd_tag);
`ifdef TAGRAM_PARITY_EN
      if (!bypass[w] && (^{vld_mem[rd_set][w], tag_mem[rd_set][w], par_mem[rd_set][w]}))
        par_err_d = 1'b1;
`endif
    end
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (match[w]) match_idx = WAYW'(w);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      sweep_cnt <= '0;
      rsp_vld   <= 1'b0;
      hit       <= 1'b0;
      hit_vec   <= '0;
      hit_idx   <= '0;
      rd_tags   <= '0;
      rd_vlds   <= '0;
      par_err   <= 1'b0;
    end else begin
      rsp_vld <= rd_acc;
      if (state == INIT) begin
        vld_mem[sweep_cnt] <= '0;
        sweep_cnt          <= sweep_cnt + AWIDTH'(1);
        if (sweep_cnt == AWIDTH'(DEPTH - 1)) state <= IDLE;
      end else if (wr_en) begin
        vld_mem[wr_set][wr_way] <= wr_vld;
      end
      if (rd_acc) begin
        hit     <= |match;
        hit_vec <= match;
        hit_idx <= match_idx;
        rd_tags <= eff_tags;
        rd_vlds <= eff_vld;
        par_err <= par_err_d;
      end
    end
  end

  // Tags are never cleared; the sweep only rewrites parity for the now-invalid entries.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (wr_acc) tag_mem[wr_set][wr_way] <= wr_tag;
`ifdef TAGRAM_PARITY_EN
      if (state == INIT) begin
        for (int w = 0; w < NWAYS; w++) par_mem[sweep_cnt][w] <= ^tag_mem[sweep_cnt][w];
      end else if (wr_en) begin
        par_mem[wr_set][wr_way] <= ^{wr_vld, wr_tag};
      end
`endif
    end
  end

endmodule

// File: tb/tb_tag_ram_nway_sync.sv
// Directed + random bench for tag_ram_nway_sync with a reference model and expected-result queue.
// Define TAGRAM_PARITY_EN for both files to exercise the parity-error path.
module tb_tag_ram_nway_sync;
  localparam int AW    = 3;
  localparam int TW    = 14;
  localparam int WB    = 1;
  localparam int NW    = 2;
  localparam int DEPTH = 8;
  localparam int W     = 1 + NW + WB + NW + 1 + NW*TW;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic              init_busy;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_set = '0;
  logic [TW-1:0]     rd_tag = '0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_set = '0;
  logic [WB-1:0]     wr_way = '0;
  logic [TW-1:0]     wr_tag = '0;
  logic              wr_vld = 1'b0;
  logic              rsp_vld;
  logic              hit;
  logic [NW-1:0]     hit_vec;
  logic [WB-1:0]     hit_idx;
  logic [NW*TW-1:0]  rd_tags;
  logic [NW-1:0]     rd_vlds;
  logic              par_err;

  tag_ram_nway_sync #(.AWIDTH(AW), .TWIDTH(TW), .WAYW(WB)) dut (
    .clock(clock), .reset(reset), .init_busy(init_busy),
    .rd_en(rd_en), .rd_set(rd_set), .rd_tag(rd_tag),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_tag(wr_tag), .wr_vld(wr_vld),
    .rsp_vld(rsp_vld), .hit(hit), .hit_vec(hit_vec), .hit_idx(hit_idx),
    .rd_tags(rd_tags), .rd_vlds(rd_vlds), .par_err(par_err)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  logic [W-1:0] last_exp = '0;
  logic [W-1:0] last_msk = '1;
  int n_checks = 0;
  int n_errors = 0;

  // reference model
  logic [TW-1:0] m_tag   [DEPTH][NW];
  bit            m_vld   [DEPTH][NW];
  bit            m_known [DEPTH][NW];
  bit            m_bad   [DEPTH][NW];
  int            busy_left = 0;

  function automatic logic [W-1:0] observed();
    return {hit, hit_vec, hit_idx, rd_vlds, par_err, rd_tags};
  endfunction

  task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick(input string name);
    logic              acc;
    logic [TW-1:0]     t;
    bit                v, kn, bad;
    logic [NW-1:0]     hv, vv;
    logic [WB-1:0]     hi;
    logic              pe;
    logic [NW*TW-1:0]  tg, tm;
    acc = !reset && (busy_left == 0);
    if (acc && rd_en) begin
      hv = '0; vv = '0; hi = '0; pe = 1'b0; tg = '0; tm = '0;
      for (int w = 0; w < NW; w++) begin
        t = m_tag[rd_set][w]; v = m_vld[rd_set][w]; kn = m_known[rd_set][w]; bad = m_bad[rd_set][w];
        if (wr_en && wr_set == rd_set && wr_way == WB'(w)) begin
          t = wr_tag; v = wr_vld; kn = 1'b1; bad = 1'b0;
        end
        hv[w] = v && (t == rd_tag);
        vv[w] = v;
        if (kn) begin
          tg[w*TW +: TW] = t;
          tm[w*TW +: TW] = '1;
        end
        if (bad) pe = 1'b1;
      end
      for (int w = NW - 1; w >= 0; w--) if (hv[w]) hi = WB'(w);
      exp_q.push_back({|hv, hv, hi, vv, pe, tg});
      msk_q.push_back({{(W - NW*TW){1'b1}}, tm});
    end
    if (acc && wr_en) begin
      m_tag[wr_set][wr_way]   = wr_tag;
      m_vld[wr_set][wr_way]   = wr_vld;
      m_known[wr_set][wr_way] = 1'b1;
      m_bad[wr_set][wr_way]   = 1'b0;
    end
    if (reset) begin
      busy_left = DEPTH;
      last_exp  = '0;
      last_msk  = '1;
    end else if (busy_left > 0) begin
      for (int w = 0; w < NW; w++) begin
        m_vld[DEPTH - busy_left][w] = 1'b0;
        m_bad[DEPTH - busy_left][w] = 1'b0;
      end
      busy_left--;
    end
    @(posedge clock);
    #1;
    check({name, " init_busy"}, W'(init_busy), W'(busy_left > 0));
    if (acc && rd_en) begin
      last_exp = exp_q.pop_front();
      last_msk = msk_q.pop_front();
      check({name, " rsp_vld"}, W'(rsp_vld), W'(1));
    end else begin
      check({name, " rsp_vld"}, W'(rsp_vld), W'(0));
    end
    check({name, " result"}, observed() & last_msk, last_exp & last_msk);
  endtask

  // driver tasks
  task automatic drive(input string name, input logic r, input logic [AW-1:0] rs, input logic [TW-1:0] rt,
                       input logic w, input logic [AW-1:0] ws, input logic [WB-1:0] ww,
                       input logic [TW-1:0] wt, input logic wv);
    rd_en = r; rd_set = rs; rd_tag = rt;
    wr_en = w; wr_set = ws; wr_way = ww; wr_tag = wt; wr_vld = wv;
    tick(name);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [AW-1:0] s, input logic [TW-1:0] t);
    drive(name, 1'b1, s, t, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic write(input string name, input logic [AW-1:0] s, input logic [WB-1:0] w,
                       input logic [TW-1:0] t, input logic v);
    drive(name, 1'b0, '0, '0, 1'b1, s, w, t, v);
  endtask

  task automatic busy_noise(input string name);
    drive(name, 1'b1, AW'($urandom_range(0, DEPTH-1)), TW'($urandom_range(0, 3)),
          1'b1, AW'($urandom_range(0, DEPTH-1)), WB'($urandom_range(0, NW-1)),
          TW'($urandom_range(0, 3)), 1'b1);
  endtask

  initial begin
    logic [AW-1:0] s;
    logic [WB-1:0] wy;
    logic [TW-1:0] tg;
    for (int i = 0; i < DEPTH; i++)
      for (int w = 0; w < NW; w++) begin
        m_tag[i][w] = '0; m_vld[i][w] = 1'b0; m_known[i][w] = 1'b0; m_bad[i][w] = 1'b0;
      end

    // reset and initial sweep with ignored requests
    tick("reset");
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_noise("sweep");
    for (int i = 0; i < DEPTH; i++) lookup("empty", AW'(i), TW'($urandom_range(0, 16383)));

    // directed fill / bypass / invalidate
    write("t2 fill", 3'd5, 1'b1, 14'h1A2B, 1'b1);
    lookup("t2 hit", 3'd5, 14'h1A2B);
    drive("t3 bypass", 1'b1, 3'd3, 14'h0042, 1'b1, 3'd3, 1'b0, 14'h0042, 1'b1);
    write("t4 inval", 3'd5, 1'b1, 14'h1A2B, 1'b0);
    lookup("t4 miss", 3'd5, 14'h1A2B);
    tick("hold");
    tick("hold");

    // duplicate tags in both ways
    write("dup w0", 3'd6, 1'b0, 14'h0155, 1'b1);
    write("dup w1", 3'd6, 1'b1, 14'h0155, 1'b1);
    lookup("dup hit", 3'd6, 14'h0155);
    lookup("dup miss", 3'd6, 14'h0156);
    drive("bypass inval", 1'b1, 3'd6, 14'h0155, 1'b1, 3'd6, 1'b0, 14'h0155, 1'b0);

    // random mixed traffic over a small tag space to force hits and collisions
    for (int i = 0; i < 40; i++) begin
      s  = AW'($urandom_range(0, DEPTH-1));
      wy = WB'($urandom_range(0, NW-1));
      tg = ($urandom_range(0, 1) == 1) ? m_tag[s][wy] : TW'($urandom_range(0, 3));
      drive("random", 1'($urandom_range(0, 1)), s, tg,
            1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? s : AW'($urandom_range(0, DEPTH-1)),
            WB'($urandom_range(0, NW-1)), TW'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
    end

    // reset in the middle of a sweep restarts it
    write("pre t5", 3'd3, 1'b0, 14'h0042, 1'b1);
    reset = 1'b1;
    tick("t5 reset a");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) busy_noise("t5 sweep a");
    reset = 1'b1;
    tick("t5 reset b");
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_noise("t5 sweep b");
    lookup("t5 cleared", 3'd3, 14'h0042);
    lookup("t5 cleared", 3'd5, 14'h1A2B);

`ifdef TAGRAM_PARITY_EN
    write("t6 fill", 3'd2, 1'b0, 14'h00F0, 1'b1);
    dut.tag_mem[2][0][3] = ~dut.tag_mem[2][0][3];
    m_tag[2][0][3] = ~m_tag[2][0][3];
    m_bad[2][0] = 1'b1;
    lookup("t6 par_err", 3'd2, 14'h00F0);
    lookup("t6 other set", 3'd1, 14'h00F0);
`else
    write("t6 fill", 3'd2, 1'b0, 14'h00F0, 1'b1);
    lookup("t6 no parity", 3'd2, 14'h00F0);
`endif
    tick("tail");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
